// File: rtl/hc4_loader.sv
// Serial program loader and 4096x8 instruction store for the HC4 core.
// Optional UART echo of received bytes is built when HC4_LOADER_ECHO_EN is defined.
`timescale 1ns/1ps
module hc4_loader #(
    parameter int          CLK_DIV   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [11:0] pc_in,
    output logic [7:0]  instruction,
    output logic        cpu_nReset,
    output logic        loading,
    output logic        load_done,
    output logic        frame_err,
    output logic        tx
);

    localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM, ST_ERROR} ld_state_t;

    rx_state_t     rx_state_r;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic          byte_valid_r;
    logic          rx_ferr_r;

    ld_state_t     ld_state_r;
    logic [11:0]   addr_r;
    logic [11:0]   len_r;
    logic [7:0]    csum_r;
    logic          cpu_nreset_r, loading_r, load_done_r, frame_err_r;
    logic          wr_en_s;

    logic [7:0]    mem_r [0:4095];

    assign instruction = mem_r[pc_in];
    assign cpu_nReset  = cpu_nreset_r;
    assign loading     = loading_r;
    assign load_done   = load_done_r;
    assign frame_err   = frame_err_r;

    // UART receiver: synchronizer, mid-bit sampling, glitch and stop-bit checks
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= CNT_ZERO;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            rx_ferr_r    <= 1'b0;
        end else begin
            rx_meta_r    <= rx;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            byte_valid_r <= 1'b0;
            rx_ferr_r    <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_cnt_r   <= HALF_M1;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_ZERO) begin
                        if (rx_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_cnt_r   <= DIV_M1;
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_ZERO) begin
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_cnt_r   <= DIV_M1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_ZERO) begin
                        byte_valid_r <= rx_sync_r;
                        rx_ferr_r    <= ~rx_sync_r;
                        rx_state_r   <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - CNT_ONE;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Frame parser with registered core-reset and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_r   <= ST_IDLE;
            addr_r       <= 12'h000;
            len_r        <= 12'h000;
            csum_r       <= 8'h00;
            cpu_nreset_r <= 1'b1;
            loading_r    <= 1'b0;
            load_done_r  <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            if (rx_ferr_r && loading_r) begin
                ld_state_r   <= ST_ERROR;
                frame_err_r  <= 1'b1;
                loading_r    <= 1'b0;
                cpu_nreset_r <= 1'b0;
            end else if (byte_valid_r) begin
                case (ld_state_r)
                    ST_IDLE, ST_ERROR: begin
                        if (rx_shift_r == SYNC_BYTE) begin
                            ld_state_r   <= ST_LEN_H;
                            addr_r       <= 12'h000;
                            csum_r       <= 8'h00;
                            frame_err_r  <= 1'b0;
                            loading_r    <= 1'b1;
                            cpu_nreset_r <= 1'b0;
                        end
                    end
                    ST_LEN_H: begin
                        len_r[11:8] <= rx_shift_r[3:0];
                        ld_state_r  <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        len_r[7:0] <= rx_shift_r;
                        ld_state_r <= ST_DATA;
                    end
                    ST_DATA: begin
                        addr_r <= addr_r + 12'd1;
                        csum_r <= csum_r + rx_shift_r;
                        // a length of 0 wraps to 0xFFF here, giving 4096 bytes
                        if (addr_r == len_r - 12'd1) begin
                            ld_state_r <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        loading_r <= 1'b0;
                        if (rx_shift_r == csum_r) begin
                            ld_state_r   <= ST_IDLE;
                            load_done_r  <= 1'b1;
                            cpu_nreset_r <= 1'b1;
                        end else begin
                            ld_state_r  <= ST_ERROR;
                            frame_err_r <= 1'b1;
                        end
                    end
                    default: begin
                        ld_state_r   <= ST_IDLE;
                        loading_r    <= 1'b0;
                        cpu_nreset_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Memory write enable for data bytes
    always_comb begin
        wr_en_s = 1'b0;
        if ((ld_state_r == ST_DATA) && byte_valid_r) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[addr_r] <= rx_shift_r;
        end
    end

`ifdef HC4_LOADER_ECHO_EN
    logic          tx_r;
    logic          tx_busy_r;
    logic [8:0]    tx_shift_r;
    logic [CW-1:0] tx_cnt_r;
    logic [3:0]    tx_bit_r;

    assign tx = tx_r;

    // UART echo transmitter; the shift register doubles as the holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_shift_r <= 9'h1FF;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 4'd0;
        end else if (!tx_busy_r) begin
            if (byte_valid_r) begin
                tx_r       <= 1'b0;
                tx_busy_r  <= 1'b1;
                tx_shift_r <= {1'b1, rx_shift_r};
                tx_cnt_r   <= DIV_M1;
                tx_bit_r   <= 4'd0;
            end
        end else if (tx_cnt_r == CNT_ZERO) begin
            tx_cnt_r <= DIV_M1;
            if (tx_bit_r == 4'd9) begin
                tx_busy_r <= 1'b0;
            end else begin
                tx_r       <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                tx_bit_r   <= tx_bit_r + 4'd1;
            end
        end else begin
            tx_cnt_r <= tx_cnt_r - CNT_ONE;
        end
    end
`else
    assign tx = 1'b1;
`endif

endmodule
